pc_gen: RTL
===========

# pc_gen

Fetch-PC generator and instruction-memory front end, directly upstream of `if_stage`. Holds the architectural fetch PC, issues single-outstanding requests to instruction memory, and applies trap/jump redirects and pipeline hold. Presents each returned instruction with its PC and a bubble mask to `if_stage` (`pc_i`, `instr_rd_i`, `instr_mask_i`). Killed and stale fetches become masked bubbles.

## Interface
- `ADDR_W`, 64: PC and fetch address width.
- `INSTR_W`, 32: instruction word width.
- `HOLD_W`, 3: hold-code width, matching `BUS_HOLD_CODE`.
- `clk` in 1: the single clock. All state updates on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `hold_code_i` in HOLD_W: the IF stage is held when `hold_code_i >= HOLD_CODE_IF`.
- `trap_en_i` in 1: trap/return redirect from CSR. Highest priority.
- `trap_addr_i` in ADDR_W: trap target.
- `jump_en_i` in 1: branch/jump redirect from EX.
- `jump_addr_i` in ADDR_W: jump target.
- `fetch_req_o` out 1: instruction memory request.
- `fetch_addr_o` out ADDR_W: request address.
- `fetch_gnt_i` in 1: request accepted this cycle.
- `fetch_rvalid_i` in 1: response data valid this cycle.
- `fetch_rdata_i` in INSTR_W: response data.
- `pc_o` out ADDR_W: PC of the presented instruction, to `if_stage.pc_i`.
- `instr_o` out INSTR_W: presented instruction, to `if_stage.instr_rd_i`.
- `instr_mask_o` out 1: `MASK_EN` means the slot is a bubble, to `if_stage.instr_mask_i`.

## Operation
- **Redirect.** `redir = trap_en_i | jump_en_i`. The target is `trap_addr_i` if `trap_en_i` is set, else `jump_addr_i`.
- **Hold.** `held = (hold_code_i >= HOLD_CODE_IF)`.
- **Registers.** `state`, `fetch_pc_q` (next address to request), `issued_pc_q`, `pend_q`, `pend_tgt_q`, and the output registers `pc_o`, `instr_o`, `instr_mask_o`.
- **Reset values.** `state = BOOT`, `fetch_pc_q = BASE_PC`, `pc_o = BASE_PC`, `instr_o = ZERO_WORD`, `instr_mask_o = MASK_EN`, `pend_q = 0`. `fetch_req_o` is 0 while `rst_n` is low.
- **`fetch_req_o`** `= (state == REQ) & ~held & ~redir`.
- **`fetch_addr_o`** `= fetch_pc_q` at all times.
- **BOOT.**
  - Go to REQ on the next edge.
  - If `redir`, load `fetch_pc_q <= target`.
- **REQ.**
  - If `redir`: `fetch_pc_q <= target` and stay in REQ. No request goes out this cycle.
  - Else if `fetch_req_o & fetch_gnt_i`: `issued_pc_q <= fetch_pc_q` and go to RESP.
- **RESP.** Wait for `fetch_rvalid_i`. No request is issued.
  - If `redir` without `rvalid`: `pend_q <= 1` and `pend_tgt_q <= target`. A later `redir` overwrites the target.
  - If `rvalid` and (`pend_q` or `redir`): drop the data, set `fetch_pc_q` to the current-cycle target (else `pend_tgt_q`), clear `pend_q`, go to REQ.
  - If `rvalid` with no redirect: `instr_o <= fetch_rdata_i`, `pc_o <= issued_pc_q`, `instr_mask_o <= ~MASK_EN`, `fetch_pc_q <= issued_pc_q + 4` (modulo 2^ADDR_W), go to REQ.
- **Presentation slot.** An unmasked instruction is consumed at every edge where `~held`. After consumption, `instr_mask_o <= MASK_EN` unless a new response loads in the same edge. While `held`, the presented outputs stay frozen.
- **Flush.** Any `redir` sets `instr_mask_o <= MASK_EN` at the next edge, overriding hold and any response load.
- **Alignment and range.** Not checked here. `if_stage` flags misaligned or out-of-range PCs.

## Timing
- **Best-case latency.** Grant at edge N, `rvalid` in cycle N+1, instruction visible on `pc_o`/`instr_o` after edge N+1.
- **Throughput.** One outstanding request. At most one instruction per two cycles.
- **Redirect to request.** A redirect in REQ produces a request for the target in the next cycle, or in the cycle after `rvalid` if the redirect arrived in RESP.
- **Hold in REQ.** Hold blocks new requests only. An outstanding response is still accepted and presented.
- **Trap and jump together.** Trap wins.
- **Mid-operation reset.** Reset during RESP returns to BOOT. A late `rvalid` that arrives after reset is ignored in BOOT/REQ.

## Structure
- **Shared defines header.** `BASE_PC`, `HOLD_CODE_IF`, `MASK_EN`, `ZERO_WORD`, `BUS_HOLD_CODE`, `BUS_ADDR_MEM`, `BUS_DATA_INSTR`, and the state encodings `PCG_BOOT`, `PCG_REQ`, `PCG_RESP`.
- **Sub-modules.** None needed. The redirect priority mux stays inline.

## Test plan
- **Reset then free-run.** Release reset with `gnt = 1` and `rvalid` one cycle after each grant → requests at 0x80000000, 0x80000004, 0x80000008. `pc_o` follows one edge after each `rvalid`, and `instr_mask_o` is 0 only on the presentation cycles.
- **Jump in REQ.** `jump_en = 1`, `jump_addr = 0x80000100`, `gnt` high → `fetch_req_o` is 0 that cycle, the next request is to 0x80000100, and the presented slot is masked.
- **Jump in RESP.** `jump_en` pulse while waiting, `rvalid` three cycles later with data 0x00000013 → the data is dropped, `instr_mask_o = 1`, and the next request is to the jump target.
- **Trap and jump in the same cycle.** Trap 0x80000200, jump 0x80000300 → the request goes to 0x80000200.
- **Hold in REQ.** `hold_code = HOLD_CODE_IF` for 3 cycles while an instruction is presented → `pc_o`/`instr_o` are frozen and no `fetch_req_o`. On release, one consumption edge passes and then the request to PC+4 is issued.
- **Reset during RESP.** Assert reset while in RESP, then a late `rvalid` arrives → state is BOOT, `pc_o = BASE_PC`, mask is 1, and the late data never appears on `instr_o`.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared constants and state encodings for the fetch-PC generator.
package pc_gen_pkg;

  localparam int BUS_HOLD_CODE  = 3;
  localparam int BUS_ADDR_MEM   = 64;
  localparam int BUS_DATA_INSTR = 32;

  localparam logic [BUS_ADDR_MEM-1:0]   BASE_PC      = 64'h0000_0000_8000_0000;
  localparam logic [BUS_HOLD_CODE-1:0]  HOLD_CODE_IF = 3'd1;
  localparam logic                      MASK_EN      = 1'b1;
  localparam logic [BUS_DATA_INSTR-1:0] ZERO_WORD    = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCG_BOOT = 2'd0,
    PCG_REQ  = 2'd1,
    PCG_RESP = 2'd2
  } pcg_state_e;

endpackage

// File: rtl/pc_gen.sv
// Fetch-PC generator: single-outstanding instruction fetch with trap/jump
// redirect, IF hold, and a one-entry presentation slot toward if_stage.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_MEM,
  parameter int INSTR_W = BUS_DATA_INSTR,
  parameter int HOLD_W  = BUS_HOLD_CODE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [HOLD_W-1:0]  hold_code_i,
  input  logic               trap_en_i,
  input  logic [ADDR_W-1:0]  trap_addr_i,
  input  logic               jump_en_i,
  input  logic [ADDR_W-1:0]  jump_addr_i,
  output logic               fetch_req_o,
  output logic [ADDR_W-1:0]  fetch_addr_o,
  input  logic               fetch_gnt_i,
  input  logic               fetch_rvalid_i,
  input  logic [INSTR_W-1:0] fetch_rdata_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_mask_o
);

  pcg_state_e        state;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] issued_pc_q;
  logic [ADDR_W-1:0] pend_tgt_q;
  logic              pend_q;

  logic              redir;
  logic              held;
  logic [ADDR_W-1:0] target;
  logic              rsp_load;

  assign redir  = trap_en_i | jump_en_i;
  assign target = trap_en_i ? trap_addr_i : jump_addr_i;
  assign held   = (hold_code_i >= HOLD_W'(HOLD_CODE_IF));

  assign fetch_req_o  = rst_n & (state == PCG_REQ) & ~held & ~redir;
  assign fetch_addr_o = fetch_pc_q;

  // A response is only presented if nothing killed the fetch in flight.
  assign rsp_load = (state == PCG_RESP) & fetch_rvalid_i & ~pend_q & ~redir;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= PCG_BOOT;
      fetch_pc_q   <= ADDR_W'(BASE_PC);
      issued_pc_q  <= ADDR_W'(BASE_PC);
      pend_tgt_q   <= ADDR_W'(BASE_PC);
      pend_q       <= 1'b0;
      pc_o         <= ADDR_W'(BASE_PC);
      instr_o      <= INSTR_W'(ZERO_WORD);
      instr_mask_o <= MASK_EN;
    end else begin
      case (state)
        PCG_BOOT: begin
          state <= PCG_REQ;
          if (redir) fetch_pc_q <= target;
        end
        PCG_REQ: begin
          if (redir) begin
            fetch_pc_q <= target;
          end else if (fetch_req_o && fetch_gnt_i) begin
            issued_pc_q <= fetch_pc_q;
            state       <= PCG_RESP;
          end
        end
        PCG_RESP: begin
          if (fetch_rvalid_i) begin
            state  <= PCG_REQ;
            pend_q <= 1'b0;
            // Same-cycle redirect is newer than any remembered one.
            if (redir)       fetch_pc_q <= target;
            else if (pend_q) fetch_pc_q <= pend_tgt_q;
            else             fetch_pc_q <= issued_pc_q + ADDR_W'(4);
          end else if (redir) begin
            pend_q     <= 1'b1;
            pend_tgt_q <= target;
          end
        end
        default: state <= PCG_BOOT;
      endcase

      // Presentation slot: flush beats load beats consume; hold freezes.
      if (redir) begin
        instr_mask_o <= MASK_EN;
      end else if (rsp_load) begin
        instr_o      <= fetch_rdata_i;
        pc_o         <= issued_pc_q;
        instr_mask_o <= ~MASK_EN;
      end else if (!held) begin
        instr_mask_o <= MASK_EN;
      end
    end
  end

endmodule
